// File: rtl/ball_serve_ctrl.sv
// ball_serve_ctrl: game-flow controller for the ball trajectory datapath.
// Runs the serve countdown, play/pause and side-wall miss detection, keeps
// both scores and drives the trajectory block's reset/pause holds.
//
// Build option: BALL_SERVE_AUTO_EN
//   defined   - POINT returns to SERVE automatically after POINT_FRAMES.
//   undefined - POINT holds (ball paused) after POINT_FRAMES until a start
//               edge; the transition into OVER stays automatic.
//
// state  | phase | meaning
// IDLE   |   0   | waiting for start, ball held in reset
// SERVE  |   1   | ball at serve position, counting SERVE_FRAMES
// PLAY   |   2   | ball moving, checking side walls every frame
// PAUSED |   3   | user pause, trajectory frozen
// POINT  |   4   | after a miss, trajectory frozen for POINT_FRAMES
// OVER   |   5   | a player reached WIN_SCORE, waiting for start

module ball_serve_ctrl #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned MISS_MARGIN  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        newFrame,
    input  logic        startBtn,
    input  logic        pauseBtn,
    input  logic [12:0] ballX,
    input  logic [12:0] wallLeft,
    input  logic [12:0] wallRight,
    output logic        ballReset,
    output logic        ballPause,
    output logic [3:0]  scoreL,
    output logic [3:0]  scoreR,
    output logic        gameOver,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_POINT  = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam logic [13:0] MARGIN14 = 14'(MISS_MARGIN);
    localparam logic [8:0]  SERVE9   = 9'(SERVE_FRAMES);
    localparam logic [8:0]  POINT9   = 9'(POINT_FRAMES);
    localparam logic [3:0]  WIN4     = 4'(WIN_SCORE);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_start_d;
    logic        r_start_edge;
    logic        r_pause_d;
    logic        r_pause_edge;
    logic [7:0]  r_cnt;
    logic [3:0]  r_score_l;
    logic [3:0]  r_score_r;
    logic        r_ball_reset;
    logic        r_ball_pause;
    logic        r_game_over;

    logic        w_miss_l;
    logic        w_miss_r;
    logic [8:0]  w_cnt_inc;
    logic        w_serve_last;
    logic        w_point_last;
    logic        w_point_done;
    logic        w_win;
    logic        w_inc_l;
    logic        w_inc_r;
    logic        w_clr_scores;

    // Widen to 14 bits so wall +/- margin can never wrap.
    assign w_miss_l     = ({1'b0, ballX} <= ({1'b0, wallLeft} + MARGIN14));
    assign w_miss_r     = (({1'b0, ballX} + MARGIN14) >= {1'b0, wallRight});
    assign w_cnt_inc    = {1'b0, r_cnt} + 9'd1;
    assign w_serve_last = newFrame && (w_cnt_inc == SERVE9);
    assign w_point_last = newFrame && (w_cnt_inc == POINT9);
    assign w_point_done = ({1'b0, r_cnt} >= POINT9);
    // Scores only move in PLAY, so in POINT this sees the just-incremented value.
    assign w_win        = (r_score_l == WIN4) || (r_score_r == WIN4);

    // Button edge detectors; the edge itself is registered, giving 2-cycle latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_d    <= 1'b0;
            r_start_edge <= 1'b0;
            r_pause_d    <= 1'b0;
            r_pause_edge <= 1'b0;
        end else begin
            r_start_d    <= startBtn;
            r_start_edge <= startBtn & ~r_start_d;
            r_pause_d    <= pauseBtn;
            r_pause_edge <= pauseBtn & ~r_pause_d;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and score-update decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_inc_l      = 1'b0;
        w_inc_r      = 1'b0;
        w_clr_scores = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_start_edge) w_state_nxt = S_SERVE;
            end
            S_SERVE: begin
                if (w_serve_last) w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                // A miss on this frame takes precedence over a pause edge.
                if (newFrame && w_miss_l) begin
                    w_inc_r     = 1'b1;
                    w_state_nxt = S_POINT;
                end else if (newFrame && w_miss_r) begin
                    w_inc_l     = 1'b1;
                    w_state_nxt = S_POINT;
                end else if (r_pause_edge) begin
                    w_state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (r_pause_edge) w_state_nxt = S_PLAY;
            end
            S_POINT: begin
`ifdef BALL_SERVE_AUTO_EN
                if (w_point_last) w_state_nxt = w_win ? S_OVER : S_SERVE;
`else
                if (w_point_last && w_win) begin
                    w_state_nxt = S_OVER;
                end else if (w_point_done && !w_win && r_start_edge) begin
                    w_state_nxt = S_SERVE;
                end
`endif
            end
            S_OVER: begin
                if (r_start_edge) begin
                    w_clr_scores = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame counter: cleared on state entry, counts frames, sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= 8'd0;
        end else if (newFrame && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Saturating scores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
        end else if (w_clr_scores) begin
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
        end else begin
            if (w_inc_l && (r_score_l != 4'hF)) r_score_l <= r_score_l + 4'd1;
            if (w_inc_r && (r_score_r != 4'hF)) r_score_r <= r_score_r + 4'd1;
        end
    end

    // Outputs decoded from next state so they change on the same edge as phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ball_reset <= 1'b1;
            r_ball_pause <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_ball_reset <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SERVE) ||
                            (w_state_nxt == S_OVER);
            r_ball_pause <= (w_state_nxt == S_PAUSED) || (w_state_nxt == S_POINT);
            r_game_over  <= (w_state_nxt == S_OVER);
        end
    end

    assign ballReset = r_ball_reset;
    assign ballPause = r_ball_pause;
    assign gameOver  = r_game_over;
    assign scoreL    = r_score_l;
    assign scoreR    = r_score_r;
    assign phase     = r_state;

endmodule

// File: tb/tb_ball_serve_ctrl.sv
// Testbench for ball_serve_ctrl: drives serves, misses, pauses and a full
// game, comparing outputs against expectations queued when stimulus is applied.
module tb_ball_serve_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        newFrame;
    logic        startBtn;
    logic        pauseBtn;
    logic [12:0] ballX;
    logic [12:0] wallLeft;
    logic [12:0] wallRight;
    logic        ballReset;
    logic        ballPause;
    logic [3:0]  scoreL;
    logic [3:0]  scoreR;
    logic        gameOver;
    logic [2:0]  phase;

    ball_serve_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .newFrame (newFrame),
        .startBtn (startBtn),
        .pauseBtn (pauseBtn),
        .ballX    (ballX),
        .wallLeft (wallLeft),
        .wallRight(wallRight),
        .ballReset(ballReset),
        .ballPause(ballPause),
        .scoreL   (scoreL),
        .scoreR   (scoreR),
        .gameOver (gameOver),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] ph;
        logic       br;
        logic       bp;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_sl    = 0;
    int   m_sr    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Expected outputs for a phase code, with scores from the bench model.
    task automatic sb_push(input string tag, input int ph);
        exp_t e;
        e.tag = tag;
        e.ph  = 3'(ph);
        e.br  = (ph == 0) || (ph == 1) || (ph == 5);
        e.bp  = (ph == 3) || (ph == 4);
        e.sl  = 4'(m_sl);
        e.sr  = 4'(m_sr);
        e.go  = (ph == 5);
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: no expectation queued");
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".phase"},     32'(phase),     32'(e.ph));
            check({e.tag, ".ballReset"}, 32'(ballReset), 32'(e.br));
            check({e.tag, ".ballPause"}, 32'(ballPause), 32'(e.bp));
            check({e.tag, ".scoreL"},    32'(scoreL),    32'(e.sl));
            check({e.tag, ".scoreR"},    32'(scoreR),    32'(e.sr));
            check({e.tag, ".gameOver"},  32'(gameOver),  32'(e.go));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            newFrame = 1'b1;
            tick();
            newFrame = 1'b0;
            tick();
        end
    endtask

    task automatic press_start();
        startBtn = 1'b1;
        tick();
        startBtn = 1'b0;
        tick();
    endtask

    task automatic press_pause();
        pauseBtn = 1'b1;
        tick();
        pauseBtn = 1'b0;
        tick();
    endtask

    task automatic serve_to_play();
        sb_push("serve_play", 2);
        frames(60);
        sb_pop_check();
    endtask

    // Miss on one frame; left_side means the ball left past the left wall.
    task automatic do_miss(input string tag, input logic [12:0] x, input bit left_side);
        ballX = x;
        if (left_side) m_sr++;
        else           m_sl++;
        sb_push(tag, 4);
        frames(1);
        sb_pop_check();
        ballX = 13'd100;
    endtask

    // From POINT (counter fresh) back to SERVE for a non-winning point.
    task automatic finish_point();
`ifdef BALL_SERVE_AUTO_EN
        sb_push("pt_auto", 1);
        frames(90);
        sb_pop_check();
`else
        sb_push("pt_hold", 4);
        frames(90);
        sb_pop_check();
        sb_push("pt_start", 1);
        press_start();
        sb_pop_check();
`endif
    endtask

    initial begin
        reset     = 1'b0;
        newFrame  = 1'b0;
        startBtn  = 1'b0;
        pauseBtn  = 1'b0;
        ballX     = 13'd100;
        wallLeft  = 13'd0;
        wallRight = 13'd200;
        repeat (3) tick();
        sb_push("reset", 0);
        sb_pop_check();
        reset = 1'b1;
        tick();
        sb_push("post_reset", 0);
        sb_pop_check();

        // Start edge: no change after one cycle, SERVE after two.
        sb_push("start_lat1", 0);
        startBtn = 1'b1;
        tick();
        sb_pop_check();
        startBtn = 1'b0;
        sb_push("start_lat2", 1);
        tick();
        sb_pop_check();

        sb_push("serve59", 1);
        frames(59);
        sb_pop_check();
        sb_push("serve60", 2);
        frames(1);
        sb_pop_check();

        // Just outside the left margin, and a miss position without a frame tick.
        ballX = 13'd5;
        sb_push("nomiss5", 2);
        frames(1);
        sb_pop_check();
        ballX = 13'd3;
        sb_push("no_frame", 2);
        tick();
        tick();
        sb_pop_check();
        do_miss("miss_left3", 13'd3, 1'b1);

        // Start before the point delay has elapsed is ignored in both builds.
        sb_push("pt89", 4);
        frames(89);
        sb_pop_check();
        sb_push("pt_early_start", 4);
        press_start();
        sb_pop_check();
`ifdef BALL_SERVE_AUTO_EN
        sb_push("pt90_auto", 1);
        frames(1);
        sb_pop_check();
`else
        sb_push("pt90_hold", 4);
        frames(1);
        sb_pop_check();
        sb_push("pt_start", 1);
        press_start();
        sb_pop_check();
`endif
        serve_to_play();

        // Pause / resume; no miss detection while paused.
        sb_push("pause", 3);
        press_pause();
        sb_pop_check();
        ballX = 13'd3;
        sb_push("paused_frame", 3);
        frames(1);
        sb_pop_check();
        ballX = 13'd100;
        sb_push("resume", 2);
        press_pause();
        sb_pop_check();

        // Pause edge and right-side miss in the same frame cycle: miss wins.
        pauseBtn = 1'b1;
        tick();
        pauseBtn = 1'b0;
        newFrame = 1'b1;
        ballX    = 13'd198;
        m_sl++;
        sb_push("same_cycle", 4);
        tick();
        sb_pop_check();
        newFrame = 1'b0;
        ballX    = 13'd100;
        sb_push("same_cycle_after", 4);
        tick();
        tick();
        sb_pop_check();
        finish_point();

        // Right player scores up to the win on the exact left-margin boundary.
        for (int i = 2; i <= 7; i++) begin
            serve_to_play();
            do_miss("miss_left4", 13'd4, 1'b1);
            if (i < 7) begin
                finish_point();
            end else begin
                sb_push("game_over", 5);
                frames(90);
                sb_pop_check();
            end
        end
        m_sl = 0;
        m_sr = 0;
        sb_push("over_start", 0);
        press_start();
        sb_pop_check();

        // Build scoreL to 3 with right-boundary misses, pause, then async reset.
        sb_push("restart", 1);
        press_start();
        sb_pop_check();
        for (int k = 0; k < 3; k++) begin
            serve_to_play();
            do_miss("miss_right196", 13'd196, 1'b0);
            finish_point();
        end
        serve_to_play();
        sb_push("pause_l3", 3);
        press_pause();
        sb_pop_check();
        #2;
        reset = 1'b0;
        #1;
        m_sl = 0;
        m_sr = 0;
        sb_push("async_reset", 0);
        sb_pop_check();
        tick();
        reset = 1'b1;
        tick();
        sb_push("after_reset", 0);
        tick();
        sb_pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
